// File: rtl/ser_bit_feeder_pkg.sv
// Shared definitions for the serial bit feeder and the detector bench driver.
// Holds the feeder FSM state encoding.
package ser_bit_feeder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } feed_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with combinational head read.
// Occupancy counter is one bit wider than the pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A pop never frees a slot for a push on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ser_bit_feeder.sv
// Parallel-to-serial feeder: queues words and streams them one bit per clock.
// Consecutive queued words are sent with no idle cycle between them.
module ser_bit_feeder
  import ser_bit_feeder_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_rdy,
  output logic             dout_vld,
  output logic             dout,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  feed_state_e state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             vld_q, vld_d;
  logic             dout_q, dout_d;
  logic             fd_q, fd_d;

  logic                   fifo_pop;
  logic [WIDTH-1:0]       fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   last_bit;
  logic                   load;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_vld && in_rdy),
    .pop_i   (fifo_pop),
    .wdata_i (in_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign in_rdy     = !fifo_full && !rst;
  assign dout_vld   = vld_q;
  assign dout       = dout_q;
  assign frame_done = fd_q;
  assign busy       = (fifo_count != '0) || (state_q == ST_SHIFT);

  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST);
  assign load     = !fifo_empty && ((state_q == ST_IDLE) || last_bit);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    vld_d    = 1'b0;
    dout_d   = 1'b0;
    fd_d     = 1'b0;
    fifo_pop = 1'b0;
    unique case (1'b1)
      load: begin
        fifo_pop = 1'b1;
        sh_d     = fifo_rdata;
        cnt_d    = '0;
        state_d  = ST_SHIFT;
        vld_d    = 1'b1;
        dout_d   = MSB_FIRST ? fifo_rdata[WIDTH-1]
                             : fifo_rdata[0];
      end
      (state_q == ST_SHIFT) && !last_bit: begin
        cnt_d  = cnt_q + CW'(1);
        vld_d  = 1'b1;
        fd_d   = (cnt_d == LAST);
        // The current bit always sits at the shifter's outgoing end.
        if (MSB_FIRST) begin
          sh_d   = {sh_q[WIDTH-2:0], 1'b0};
          dout_d = sh_q[WIDTH-2];
        end else begin
          sh_d   = {1'b0, sh_q[WIDTH-1:1]};
          dout_d = sh_q[1];
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      vld_q   <= 1'b0;
      dout_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      vld_q   <= vld_d;
      dout_q  <= dout_d;
      fd_q    <= fd_d;
    end
  end

endmodule
